// File: rtl/pmm_pkg.sv
// Shared constants and types for the pattern-matching engine host driver.
// Opcodes, engine address map and the driver FSM state encoding.
package pmm_pkg;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_CFG = 2'b01;
    localparam logic [1:0] OP_SIM = 2'b10;
    localparam logic [1:0] OP_RST = 2'b11;

    // Per-character tables are 8 bytes apart (char c at base + 8*c).
    localparam logic [13:0] ADDR_REPPOS  = 14'h0000;
    localparam logic [13:0] ADDR_MOVE    = 14'h0800;
    localparam logic [13:0] ADDR_EPS_BEG = 14'h1000;
    localparam logic [13:0] ADDR_EPS_BLK = 14'h1008;
    localparam logic [13:0] ADDR_EPS_END = 14'h1010;
    localparam logic [13:0] ADDR_INIT    = 14'h1018;
    localparam logic [13:0] ADDR_ACCEPT  = 14'h1020;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2,
        RSP  = 2'd3
    } drv_state_e;

endpackage

// File: rtl/pmm_host_driver.sv
// Four-phase command bus initiator for the pattern-matching engine.
// Optional REQ-phase timeout is enabled with `define PMM_DRV_TIMEOUT_EN.
module pmm_host_driver
    import pmm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [13:0]      cmd_addr,
    input  logic [63:0]      cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_op,
    output logic             rsp_match,
    output logic             rsp_timeout,
    output logic [CNT_W-1:0] char_count,
    output logic [CNT_W-1:0] match_count,
    output logic [63:0]      INP_DATA,
    output logic [15:0]      INP_CONTROL,
    output logic             DATA_VALID,
    input  logic             READY_STATUS,
    input  logic             ACCEPTED_STATUS
);

    if (TIMEOUT_CYCLES < 1 || CNT_W < 1) begin : g_bad_param
        $error("pmm_host_driver: parameters must be positive");
    end

    drv_state_e       state_q, state_d;
    logic             dv_q, dv_d;
    logic [63:0]      data_q, data_d;
    logic [15:0]      ctrl_q, ctrl_d;
    logic             rvalid_q, rvalid_d;
    logic [1:0]       rop_q, rop_d;
    logic             rmatch_q, rmatch_d;
    logic [CNT_W-1:0] char_q, char_d;
    logic [CNT_W-1:0] match_q, match_d;
    logic             aborted;

`ifdef PMM_DRV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          rtmo_q, rtmo_d;

    assign aborted     = rtmo_q;
    assign rsp_timeout = rtmo_q;
`else
    assign aborted     = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        dv_d      = dv_q;
        data_d    = data_q;
        ctrl_d    = ctrl_q;
        rvalid_d  = rvalid_q;
        rop_d     = rop_q;
        rmatch_d  = rmatch_q;
        char_d    = char_q;
        match_d   = match_q;
`ifdef PMM_DRV_TIMEOUT_EN
        tmo_d     = tmo_q;
        rtmo_d    = rtmo_q;
`endif
        // Never start a command while the engine still holds the last ack.
        cmd_ready = (state_q == IDLE) && !READY_STATUS;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    rop_d    = cmd_op;
                    rmatch_d = 1'b0;
`ifdef PMM_DRV_TIMEOUT_EN
                    rtmo_d   = 1'b0;
                    tmo_d    = '0;
`endif
                    if (cmd_op == OP_NOP) begin
                        rvalid_d = 1'b1;
                        state_d  = RSP;
                    end else begin
                        data_d  = cmd_data;
                        ctrl_d  = {cmd_op, cmd_addr};
                        dv_d    = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (READY_STATUS) begin
                    rmatch_d = (rop_q == OP_SIM) && ACCEPTED_STATUS;
                    dv_d     = 1'b0;
                    state_d  = REL;
                end
`ifdef PMM_DRV_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    rmatch_d = 1'b0;
                    rtmo_d   = 1'b1;
                    dv_d     = 1'b0;
                    state_d  = REL;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
`endif
            end
            REL: begin
                if (!READY_STATUS) begin
                    rvalid_d = 1'b1;
                    state_d  = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                    if (!aborted && rop_q == OP_SIM) begin
                        char_d  = char_q + CNT_W'(1);
                        match_d = match_q + CNT_W'(rmatch_q);
                    end
                    if (!aborted && rop_q == OP_RST) begin
                        char_d  = '0;
                        match_d = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dv_q     <= 1'b0;
            data_q   <= '0;
            ctrl_q   <= '0;
            rvalid_q <= 1'b0;
            rop_q    <= OP_NOP;
            rmatch_q <= 1'b0;
            char_q   <= '0;
            match_q  <= '0;
`ifdef PMM_DRV_TIMEOUT_EN
            tmo_q    <= '0;
            rtmo_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            dv_q     <= dv_d;
            data_q   <= data_d;
            ctrl_q   <= ctrl_d;
            rvalid_q <= rvalid_d;
            rop_q    <= rop_d;
            rmatch_q <= rmatch_d;
            char_q   <= char_d;
            match_q  <= match_d;
`ifdef PMM_DRV_TIMEOUT_EN
            tmo_q    <= tmo_d;
            rtmo_q   <= rtmo_d;
`endif
        end
    end

    assign DATA_VALID  = dv_q;
    assign INP_DATA    = data_q;
    assign INP_CONTROL = ctrl_q;
    assign rsp_valid   = rvalid_q;
    assign rsp_op      = rop_q;
    assign rsp_match   = rmatch_q;
    assign char_count  = char_q;
    assign match_count = match_q;

endmodule

// File: tb/tb_pmm_host_driver.sv
// Bench for pmm_host_driver: engine model on the bus, command-level
// reference model for responses and statistics counters.
module tb_pmm_host_driver;
    import pmm_pkg::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [13:0]   cmd_addr;
    logic [63:0]   cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_op;
    logic          rsp_match;
    logic          rsp_timeout;
    logic [CW-1:0] char_count;
    logic [CW-1:0] match_count;
    logic [63:0]   INP_DATA;
    logic [15:0]   INP_CONTROL;
    logic          DATA_VALID;
    logic          READY_STATUS;
    logic          ACCEPTED_STATUS;

    pmm_host_driver #(
        .TIMEOUT_CYCLES(8),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_addr(cmd_addr),
        .cmd_data(cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_op(rsp_op),
        .rsp_match(rsp_match),
        .rsp_timeout(rsp_timeout),
        .char_count(char_count),
        .match_count(match_count),
        .INP_DATA(INP_DATA),
        .INP_CONTROL(INP_CONTROL),
        .DATA_VALID(DATA_VALID),
        .READY_STATUS(READY_STATUS),
        .ACCEPTED_STATUS(ACCEPTED_STATUS)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Engine model: acks after eng_lat cycles, applies CFG/RST, answers SIM.
    int          eng_lat = 0;
    bit          eng_dead = 1'b0;
    int          eng_cnt;
    logic [63:0] e_init, e_acc;
    logic [63:0] e_move [256];
    logic [63:0] seen_data;
    logic [15:0] seen_ctrl;
    logic [1:0]  e_op;
    logic [13:0] e_addr;

    assign e_op   = INP_CONTROL[15:14];
    assign e_addr = INP_CONTROL[13:0];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            READY_STATUS    <= 1'b0;
            ACCEPTED_STATUS <= 1'b0;
            eng_cnt         <= 0;
        end else if (!DATA_VALID) begin
            READY_STATUS <= 1'b0;
            eng_cnt      <= 0;
        end else if (!READY_STATUS && !eng_dead) begin
            if (eng_cnt >= eng_lat) begin
                READY_STATUS <= 1'b1;
                seen_ctrl    <= INP_CONTROL;
                seen_data    <= INP_DATA;
                if (e_op == OP_SIM)
                    ACCEPTED_STATUS <=
                        |(e_init & e_move[INP_DATA[7:0]] & e_acc);
                else
                    ACCEPTED_STATUS <= 1'($urandom_range(0, 1));
                if (e_op == OP_RST) begin
                    e_init <= '0;
                    e_acc  <= '0;
                    for (int i = 0; i < 256; i++) e_move[i] <= '0;
                end else if (e_op == OP_CFG) begin
                    if (e_addr == ADDR_INIT)
                        e_init <= INP_DATA;
                    else if (e_addr == ADDR_ACCEPT)
                        e_acc <= INP_DATA;
                    else if (e_addr >= ADDR_MOVE && e_addr < ADDR_EPS_BEG)
                        e_move[8'((e_addr - ADDR_MOVE) >> 3)] <= INP_DATA;
                end
            end else begin
                eng_cnt <= eng_cnt + 1;
            end
        end
    end

    // Command-level reference model.
    logic [63:0]   m_init, m_acc;
    logic [63:0]   m_move [256];
    logic [CW-1:0] char_m, match_m;

    function automatic logic exp_match(input logic [7:0] c);
        return |(m_init & m_move[c] & m_acc);
    endfunction

    task automatic model_clear_cfg();
        m_init = '0;
        m_acc  = '0;
        for (int i = 0; i < 256; i++) m_move[i] = '0;
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [13:0] addr,
                          input logic [63:0] data, input int hold,
                          input bit exp_to, output int lat, output int dvc);
        logic em;
        bit   bad;
        int   n;
        em = (op == OP_SIM && !exp_to) ? exp_match(data[7:0]) : 1'b0;
        @(negedge clk);
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready", cmd_ready, 1'b1);
        // Accept edge E0 lies between here and the next negedge.
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 0;
        dvc = 0;
        while (!rsp_valid && lat < 100) begin
            if (DATA_VALID) dvc++;
            @(negedge clk);
            lat++;
        end
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_op", rsp_op, op);
        chk("rsp_match", rsp_match, em);
        chk("rsp_timeout", rsp_timeout, exp_to);
        if (op != OP_NOP && !exp_to) begin
            chk("bus_ctrl", seen_ctrl, {op, addr});
            chk("bus_data", seen_data, data);
        end
        bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_op != op || rsp_match != em || cmd_ready)
                bad = 1'b1;
        end
        if (hold > 0) chk("hold_stable", bad, 1'b0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        if (!exp_to) begin
            case (op)
                OP_SIM: begin
                    char_m  = char_m + 1'b1;
                    match_m = match_m + CW'(em);
                end
                OP_RST: begin
                    char_m  = '0;
                    match_m = '0;
                    model_clear_cfg();
                end
                OP_CFG: begin
                    if (addr == ADDR_INIT) m_init = data;
                    else if (addr == ADDR_ACCEPT) m_acc = data;
                    else if (addr >= ADDR_MOVE && addr < ADDR_EPS_BEG)
                        m_move[8'((addr - ADDR_MOVE) >> 3)] = data;
                end
                default: ;
            endcase
        end
        chk("rsp_drop", rsp_valid, 1'b0);
        chk("char_count", char_count, char_m);
        chk("match_count", match_count, match_m);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, dvc, r, k;
        logic [1:0]  op;
        logic [13:0] addr;
        logic [63:0] data;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_addr  = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        char_m    = '0;
        match_m   = '0;
        model_clear_cfg();

        @(negedge clk);
        chk("rst_dv", DATA_VALID, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_ctrl", INP_CONTROL, 16'h0);
        chk("rst_char", char_count, '0);
        chk("rst_match", match_count, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean engine configuration, then the reference program.
        do_cmd(OP_RST, 14'h0, 64'h0, 0, 1'b0, lat, dvc);
        do_cmd(OP_CFG, ADDR_INIT, 64'h1, 0, 1'b0, lat, dvc);
        chk("cfg_lat", lat, 4);
        chk("cfg_dv_cycles", dvc, 2);
        do_cmd(OP_CFG, 14'(ADDR_MOVE + 8 * 8'h61), 64'h1, 0, 1'b0, lat, dvc);
        chk("cfg_move_lat", lat, 4);
        do_cmd(OP_CFG, ADDR_ACCEPT, 64'h1, 0, 1'b0, lat, dvc);
        do_cmd(OP_SIM, 14'h0, 64'h61, 0, 1'b0, lat, dvc);
        chk("sim_lat", lat, 4);
        chk("sim_hit_char", char_count, 1);
        chk("sim_hit_match", match_count, 1);
        do_cmd(OP_SIM, 14'h0, 64'h62, 0, 1'b0, lat, dvc);
        chk("sim_miss_char", char_count, 2);
        chk("sim_miss_match", match_count, 1);

        // NOP: response in the cycle right after the accept edge.
        do_cmd(OP_NOP, 14'h0, 64'h0, 10, 1'b0, lat, dvc);
        chk("nop_lat", lat, 0);
        chk("nop_dv_cycles", dvc, 0);
        do_cmd(OP_SIM, 14'h155, 64'hA5A5_0000_0000_0061, 10, 1'b0, lat, dvc);

`ifdef PMM_DRV_TIMEOUT_EN
        eng_dead = 1'b1;
        do_cmd(OP_SIM, 14'h0, 64'h61, 0, 1'b1, lat, dvc);
        chk("tmo_dv_cycles", dvc, 8);
        eng_dead = 1'b0;
`endif

        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            addr = 14'($urandom_range(0, 16383));
            data = {32'($urandom), 32'($urandom)};
            if (r == 0) begin
                op = OP_NOP;
            end else if (r == 1) begin
                op = OP_RST;
            end else if (r < 6) begin
                op = OP_CFG;
                k = $urandom_range(0, 3);
                data = 64'($urandom_range(0, 7));
                if (k == 0) addr = ADDR_INIT;
                else if (k == 1) addr = ADDR_ACCEPT;
                else addr = 14'(ADDR_MOVE + 8 * (8'h61 + $urandom_range(0, 3)));
            end else begin
                op = OP_SIM;
                data[7:0] = 8'(8'h61 + $urandom_range(0, 3));
            end
            eng_lat = $urandom_range(0, 3);
            do_cmd(op, addr, data, $urandom_range(0, 3), 1'b0, lat, dvc);
        end
        eng_lat = 0;

        // Asynchronous reset while the driver waits in REQ.
        eng_dead = 1'b1;
        @(negedge clk);
        cmd_op    = OP_SIM;
        cmd_addr  = 14'h0;
        cmd_data  = 64'h61;
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("areset_pre_dv", DATA_VALID, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_dv", DATA_VALID, 1'b0);
        chk("areset_rsp_valid", rsp_valid, 1'b0);
        chk("areset_char", char_count, '0);
        chk("areset_match", match_count, '0);
        @(negedge clk);
        rst_n    = 1'b1;
        eng_dead = 1'b0;
        char_m   = '0;
        match_m  = '0;
        @(negedge clk);
        chk("post_reset_idle", cmd_ready, 1'b1);
        chk("post_reset_char", char_count, '0);
        do_cmd(OP_SIM, 14'h0, 64'h61, 0, 1'b0, lat, dvc);
        chk("post_reset_lat", lat, 4);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
